// File: rtl/velocidad_pkg.sv
// ---------------------------------------------------------------------------
// velocidad_pkg
// Shared definitions for the per-channel velocity estimator:
//   - velState_e  : controller state encoding
//   - FLAG_*      : bit positions inside vel_flags
//   - KMH_*       : fixed-point factor for m/s -> km/h (922/256 ~= 3.6)
//   - numWidth()  : numerator width wide enough for |dd| * CLK_HZ
// ---------------------------------------------------------------------------
package velocidad_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DIVIDE = 3'd2,
        SIGN   = 3'd3,
        HOLD   = 3'd4
    } velState_e;

    localparam int FLAG_STALE = 0;
    localparam int FLAG_SAT   = 1;

    localparam int KMH_MUL   = 922;
    localparam int KMH_SHIFT = 8;

    // |dd| never exceeds 2^dispW - 1 and clkHz <= 2^clog2(clkHz), so the
    // product always fits in dispW + clog2(clkHz) bits.
    function automatic int numWidth(input int dispW, input int clkHz);
        return dispW + $clog2(clkHz);
    endfunction

endpackage

// File: rtl/div_restoring.sv
// ---------------------------------------------------------------------------
// div_restoring
// Unsigned restoring divider, one quotient bit per clock. A start pulse
// loads the operands; NUM_W cycles later done pulses for one cycle and
// quotient holds the result until the next start.
//
// Ports:
//   clock        in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   load numerator/denominator and begin
//   numerator    in   NUM_W dividend
//   denominator  in   DEN_W divisor (caller guarantees non-zero)
//   done         out  one-cycle pulse when quotient is final
//   quotient     out  NUM_W result
// ---------------------------------------------------------------------------
module div_restoring #(
    parameter int NUM_W = 42,
    parameter int DEN_W = 25
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [NUM_W-1:0] numerator,
    input  logic [DEN_W-1:0] denominator,
    output logic             done,
    output logic [NUM_W-1:0] quotient
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [DEN_W-1:0] remReg;
    logic [DEN_W-1:0] denReg;
    logic [CNT_W-1:0] bitCnt;
    logic             busy;
    logic [DEN_W:0]   shifted;
    logic [DEN_W:0]   trial;
    logic             fits;

    // The quotient register doubles as the dividend shift register: its MSB
    // feeds the partial remainder while the new quotient bit enters at bit 0.
    // The remainder stays below the divisor, so one extra bit is enough to
    // detect the borrow of the trial subtraction.
    assign shifted = {remReg, quotient[NUM_W-1]};
    assign trial   = shifted - {1'b0, denReg};
    assign fits    = ~trial[DEN_W];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            remReg   <= '0;
            denReg   <= '0;
            quotient <= '0;
            bitCnt   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                remReg   <= '0;
                denReg   <= denominator;
                quotient <= numerator;
                bitCnt   <= CNT_W'(NUM_W);
                busy     <= 1'b1;
            end else if (busy) begin
                remReg   <= fits ? trial[DEN_W-1:0] : shifted[DEN_W-1:0];
                quotient <= {quotient[NUM_W-2:0], fits};
                bitCnt   <= bitCnt - CNT_W'(1);
                if (bitCnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/velocidad_canales.sv
// ---------------------------------------------------------------------------
// velocidad_canales
// Multi-channel velocity estimator. Each channel remembers its last absolute
// displacement and the ticks elapsed since then; a new sample produces
// velocity = (disp - lastDisp) * CLK_HZ / (elapsed + 1) in units per second.
// One division is in flight at a time; input is back-pressured meanwhile.
//
// Optional feature: define KMH_OUT_EN to add vel_kmh = sat((vel_value*922)>>>8).
//
// Ports:
//   clock          in   sole clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   sample_valid   in   sample offered
//   sample_ready   out  sample accepted when valid && ready
//   sample_ch      in   channel index of the sample
//   sample_disp    in   absolute displacement (unsigned)
//   vel_valid      out  result available
//   vel_ready      in   result consumed when valid && ready
//   vel_ch         out  channel of the result
//   vel_value      out  signed velocity, saturated to VEL_W
//   vel_flags      out  bit0 stale (elapsed saturated), bit1 result clamped
//   vel_kmh        out  (KMH_OUT_EN only) velocity scaled by 3.6, saturated
//
// state  | meaning
// IDLE   | ready for samples; first samples of a channel are absorbed here
// LOAD   | form |dd|*CLK_HZ and start the divider, or report a stale result
// DIVIDE | restoring division, one quotient bit per cycle
// SIGN   | reapply sign of dd, clamp to VEL_W, register outputs
// HOLD   | outputs stable until vel_ready
// ---------------------------------------------------------------------------
module velocidad_canales
    import velocidad_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int DISP_W   = 32,
    parameter  int TIME_W   = 24,
    parameter  int VEL_W    = 24,
    parameter  int CLK_HZ   = 100000000,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic [CH_W-1:0]         sample_ch,
    input  logic [DISP_W-1:0]       sample_disp,
    output logic                    vel_valid,
    input  logic                    vel_ready,
    output logic [CH_W-1:0]         vel_ch,
    output logic signed [VEL_W-1:0] vel_value,
    output logic [1:0]              vel_flags
`ifdef KMH_OUT_EN
    ,
    output logic signed [VEL_W-1:0] vel_kmh
`endif
);

    localparam int NUM_W = numWidth(DISP_W, CLK_HZ);
    localparam int DEN_W = TIME_W + 1;
    localparam int CMP_W = ((NUM_W > VEL_W) ? NUM_W : VEL_W) + 1;

    localparam logic [TIME_W-1:0]       ELAPSED_MAX = '1;
    localparam logic [CMP_W-1:0]        POS_LIM     = (CMP_W'(1) << (VEL_W - 1)) - CMP_W'(1);
    localparam logic [CMP_W-1:0]        NEG_LIM     = CMP_W'(1) << (VEL_W - 1);
    localparam logic signed [VEL_W-1:0] VEL_MAX     = {1'b0, {(VEL_W - 1){1'b1}}};
    localparam logic signed [VEL_W-1:0] VEL_MIN     = {1'b1, {(VEL_W - 1){1'b0}}};

    velState_e state;
    velState_e nextState;

    logic [DISP_W-1:0]   lastDisp [CHANNELS];
    logic [TIME_W-1:0]   elapsed  [CHANNELS];
    logic [CHANNELS-1:0] firstSeen;

    logic                accept;
    logic                chInRange;
    logic                doCompute;
    logic [TIME_W-1:0]   elapsedSel;
    logic signed [DISP_W:0] ddSample;
    logic [DISP_W-1:0]   absDdSample;

    logic [CH_W-1:0]     chReg;
    logic [DISP_W-1:0]   absDdReg;
    logic                ddNegReg;
    logic [DEN_W-1:0]    dtReg;
    logic                staleReg;

    logic                divStart;
    logic                divDone;
    logic [NUM_W-1:0]    numLoad;
    logic [NUM_W-1:0]    divQuotient;

    logic [CMP_W-1:0]    quoExt;
    logic signed [VEL_W-1:0] satValue;
    logic                satFlag;
    logic [1:0]          flagsStale;
    logic [1:0]          flagsSign;

    // Channel indices beyond CHANNELS-1 are accepted but ignored.
    assign chInRange   = (32'(sample_ch) < 32'(CHANNELS));
    assign accept      = sample_valid && sample_ready;
    assign doCompute   = accept && chInRange && firstSeen[sample_ch];
    assign elapsedSel  = elapsed[sample_ch];
    assign ddSample    = $signed({1'b0, sample_disp}) - $signed({1'b0, lastDisp[sample_ch]});
    assign absDdSample = ddSample[DISP_W] ? DISP_W'(-ddSample) : ddSample[DISP_W-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                lastDisp[i] <= '0;
                elapsed[i]  <= '0;
            end
            firstSeen <= '0;
            chReg     <= '0;
            absDdReg  <= '0;
            ddNegReg  <= 1'b0;
            dtReg     <= '0;
            staleReg  <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (accept && chInRange && (sample_ch == CH_W'(i))) begin
                    lastDisp[i]  <= sample_disp;
                    firstSeen[i] <= 1'b1;
                    elapsed[i]   <= '0;
                end else if (elapsed[i] != ELAPSED_MAX) begin
                    elapsed[i] <= elapsed[i] + TIME_W'(1);
                end
            end
            if (doCompute) begin
                chReg    <= sample_ch;
                absDdReg <= absDdSample;
                ddNegReg <= ddSample[DISP_W];
                dtReg    <= DEN_W'(elapsedSel) + DEN_W'(1);
                staleReg <= (elapsedSel == ELAPSED_MAX);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            sample_ready <= 1'b0;
        end else begin
            state        <= nextState;
            sample_ready <= (nextState == IDLE);
        end
    end

    always_comb begin
        nextState = state;
        divStart  = 1'b0;
        unique case (state)
            IDLE:   if (doCompute) nextState = LOAD;
            LOAD: begin
                if (staleReg) begin
                    nextState = HOLD;
                end else begin
                    nextState = DIVIDE;
                    divStart  = 1'b1;
                end
            end
            DIVIDE: if (divDone) nextState = SIGN;
            SIGN:   nextState = HOLD;
            HOLD:   if (vel_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign numLoad = NUM_W'(absDdReg) * NUM_W'(CLK_HZ);

    div_restoring #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W)
    ) uDiv (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (divStart),
        .numerator   (numLoad),
        .denominator (dtReg),
        .done        (divDone),
        .quotient    (divQuotient)
    );

    // Negative side allows one more magnitude step than the positive side.
    always_comb begin
        quoExt   = CMP_W'(divQuotient);
        satValue = '0;
        satFlag  = 1'b0;
        if (!ddNegReg) begin
            satValue = VEL_W'(divQuotient);
            if (quoExt > POS_LIM) begin
                satValue = VEL_MAX;
                satFlag  = 1'b1;
            end
        end else begin
            satValue = -VEL_W'(divQuotient);
            if (quoExt > NEG_LIM) begin
                satValue = VEL_MIN;
                satFlag  = 1'b1;
            end
        end
    end

    always_comb begin
        flagsStale             = '0;
        flagsStale[FLAG_STALE] = 1'b1;
        flagsSign              = '0;
        flagsSign[FLAG_SAT]    = satFlag;
    end

`ifdef KMH_OUT_EN
    localparam int KP_W = VEL_W + $clog2(KMH_MUL) + 1;
    localparam logic signed [KP_W-1:0] KMH_HI = KP_W'(VEL_MAX);
    localparam logic signed [KP_W-1:0] KMH_LO = KP_W'(VEL_MIN);

    logic signed [KP_W-1:0]  kmhProd;
    logic signed [KP_W-1:0]  kmhShift;
    logic signed [VEL_W-1:0] kmhSat;

    always_comb begin
        kmhProd  = KP_W'(satValue) * KP_W'(KMH_MUL);
        kmhShift = kmhProd >>> KMH_SHIFT;
        if (kmhShift > KMH_HI) begin
            kmhSat = VEL_MAX;
        end else if (kmhShift < KMH_LO) begin
            kmhSat = VEL_MIN;
        end else begin
            kmhSat = VEL_W'(kmhShift);
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vel_valid <= 1'b0;
            vel_ch    <= '0;
            vel_value <= '0;
            vel_flags <= '0;
`ifdef KMH_OUT_EN
            vel_kmh   <= '0;
`endif
        end else begin
            if (state == LOAD && staleReg) begin
                vel_valid <= 1'b1;
                vel_ch    <= chReg;
                vel_value <= '0;
                vel_flags <= flagsStale;
`ifdef KMH_OUT_EN
                vel_kmh   <= '0;
`endif
            end else if (state == SIGN) begin
                vel_valid <= 1'b1;
                vel_ch    <= chReg;
                vel_value <= satValue;
                vel_flags <= flagsSign;
`ifdef KMH_OUT_EN
                vel_kmh   <= kmhSat;
`endif
            end else if (state == HOLD && vel_ready) begin
                vel_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_velocidad_canales.sv
module tb_velocidad_canales;

    // NUM_W = 32 displacement bits + clog2(1000) = 42; result after NUM_W+3 edges.
    localparam int LAT_DIV   = 45;
    localparam int LAT_STALE = 1;

    logic               clock;
    logic               reset_n;
    logic               sample_valid;
    logic               sample_ready;
    logic [1:0]         sample_ch;
    logic [31:0]        sample_disp;
    logic               vel_valid;
    logic               vel_ready;
    logic [1:0]         vel_ch;
    logic signed [23:0] vel_value;
    logic [1:0]         vel_flags;

    int total = 0;
    int bad   = 0;

    velocidad_canales #(
        .CHANNELS (4),
        .DISP_W   (32),
        .TIME_W   (8),
        .VEL_W    (24),
        .CLK_HZ   (1000)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_ch    (sample_ch),
        .sample_disp  (sample_disp),
        .vel_valid    (vel_valid),
        .vel_ready    (vel_ready),
        .vel_ch       (vel_ch),
        .vel_value    (vel_value),
        .vel_flags    (vel_flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic waitEdges(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pushSample(input logic [1:0] ch, input logic [31:0] disp);
        sample_valid = 1'b1;
        sample_ch    = ch;
        sample_disp  = disp;
        @(posedge clock);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!vel_valid && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic watchQuiet(input int n, output int seen);
        seen = 0;
        repeat (n) begin
            @(posedge clock);
            #1;
            if (vel_valid) seen++;
        end
    endtask

    task automatic releaseResult;
        vel_ready = 1'b1;
        @(posedge clock);
        #1;
        vel_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #3;
        total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b want=0", sample_ready); end
        total++; if (vel_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", vel_valid); end
        total++; if (vel_value !== 24'sd0) begin bad++; $display("FAIL rst_value got=%0d want=0", vel_value); end
        total++; if (vel_flags !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b want=00", vel_flags); end
        total++; if (vel_ch !== 2'd0) begin bad++; $display("FAIL rst_ch got=%0d want=0", vel_ch); end
        waitEdges(2);
        total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_held got=%0b want=0", sample_ready); end
        reset_n = 1'b1;
        #1;
        total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_release got=%0b want=0", sample_ready); end
        waitEdges(1);
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_first_edge got=%0b want=1", sample_ready); end
    endtask

    task automatic test_first_and_latency;
        int seen;
        int lat;
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL ch0_ready got=%0b want=1", sample_ready); end
        pushSample(2'd0, 32'd16430);
        watchQuiet(99, seen);
        total++; if (seen !== 0) begin bad++; $display("FAIL ch0_first_no_output got=%0d want=0", seen); end
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL ch0_ready_after_first got=%0b want=1", sample_ready); end
        pushSample(2'd0, 32'd16686);
        total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL ch0_ready_busy got=%0b want=0", sample_ready); end
        waitResult(lat);
        total++; if (lat !== LAT_DIV) begin bad++; $display("FAIL ch0_latency got=%0d want=%0d", lat, LAT_DIV); end
        total++; if (vel_value !== 24'sd2560) begin bad++; $display("FAIL ch0_value got=%0d want=2560", vel_value); end
        total++; if (vel_flags !== 2'b00) begin bad++; $display("FAIL ch0_flags got=%b want=00", vel_flags); end
        total++; if (vel_ch !== 2'd0) begin bad++; $display("FAIL ch0_ch got=%0d want=0", vel_ch); end
    endtask

    task automatic test_hold_stall;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            total++;
            if (vel_valid !== 1'b1 || vel_value !== 24'sd2560 || vel_flags !== 2'b00 ||
                vel_ch !== 2'd0 || sample_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_stable cyc=%0d got valid=%0b value=%0d flags=%b ch=%0d ready=%0b want 1/2560/00/0/0",
                         i, vel_valid, vel_value, vel_flags, vel_ch, sample_ready);
            end
        end
        releaseResult();
        total++; if (vel_valid !== 1'b0) begin bad++; $display("FAIL hold_valid_drop got=%0b want=0", vel_valid); end
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL hold_ready_back got=%0b want=1", sample_ready); end
    endtask

    task automatic test_negative;
        int lat;
        pushSample(2'd1, 32'd17094);
        waitEdges(49);
        pushSample(2'd1, 32'd17018);
        waitResult(lat);
        total++; if (lat !== LAT_DIV) begin bad++; $display("FAIL ch1_latency got=%0d want=%0d", lat, LAT_DIV); end
        total++; if (vel_value !== -24'sd1520) begin bad++; $display("FAIL ch1_value got=%0d want=-1520", vel_value); end
        total++; if (vel_flags !== 2'b00) begin bad++; $display("FAIL ch1_flags got=%b want=00", vel_flags); end
        total++; if (vel_ch !== 2'd1) begin bad++; $display("FAIL ch1_ch got=%0d want=1", vel_ch); end
        releaseResult();
        total++; if (vel_valid !== 1'b0) begin bad++; $display("FAIL ch1_release got=%0b want=0", vel_valid); end
    endtask

    task automatic test_zero_delta;
        int lat;
        waitEdges(5);
        pushSample(2'd1, 32'd17018);
        waitResult(lat);
        total++; if (lat !== LAT_DIV) begin bad++; $display("FAIL zero_latency got=%0d want=%0d", lat, LAT_DIV); end
        total++; if (vel_value !== 24'sd0) begin bad++; $display("FAIL zero_value got=%0d want=0", vel_value); end
        total++; if (vel_flags !== 2'b00) begin bad++; $display("FAIL zero_flags got=%b want=00", vel_flags); end
        releaseResult();
    endtask

    task automatic test_stale;
        int lat;
        pushSample(2'd2, 32'd500);
        waitEdges(265);
        pushSample(2'd2, 32'd900);
        waitResult(lat);
        total++; if (lat !== LAT_STALE) begin bad++; $display("FAIL stale_latency got=%0d want=%0d", lat, LAT_STALE); end
        total++; if (vel_value !== 24'sd0) begin bad++; $display("FAIL stale_value got=%0d want=0", vel_value); end
        total++; if (vel_flags !== 2'b01) begin bad++; $display("FAIL stale_flags got=%b want=01", vel_flags); end
        total++; if (vel_ch !== 2'd2) begin bad++; $display("FAIL stale_ch got=%0d want=2", vel_ch); end
        releaseResult();
    endtask

    task automatic test_saturate;
        int lat;
        pushSample(2'd3, 32'd0);
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL sat_ready_b2b got=%0b want=1", sample_ready); end
        pushSample(2'd3, 32'hFFFF_FFFF);
        waitResult(lat);
        total++; if (lat !== LAT_DIV) begin bad++; $display("FAIL sat_latency got=%0d want=%0d", lat, LAT_DIV); end
        total++; if (vel_value !== 24'sd8388607) begin bad++; $display("FAIL sat_value got=%0d want=8388607", vel_value); end
        total++; if (vel_flags !== 2'b10) begin bad++; $display("FAIL sat_flags got=%b want=10", vel_flags); end
        total++; if (vel_ch !== 2'd3) begin bad++; $display("FAIL sat_ch got=%0d want=3", vel_ch); end
        releaseResult();
    endtask

    task automatic test_reset_abort;
        int seen;
        int lat;
        waitEdges(3);
        pushSample(2'd3, 32'd100);
        waitEdges(10);
        reset_n = 1'b0;
        #1;
        total++; if (sample_ready !== 1'b0) begin bad++; $display("FAIL abort_ready_in_reset got=%0b want=0", sample_ready); end
        waitEdges(2);
        total++; if (vel_valid !== 1'b0) begin bad++; $display("FAIL abort_valid_in_reset got=%0b want=0", vel_valid); end
        reset_n = 1'b1;
        waitEdges(1);
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL abort_ready_after got=%0b want=1", sample_ready); end
        watchQuiet(60, seen);
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_output got=%0d want=0", seen); end
        pushSample(2'd0, 32'd1000);
        watchQuiet(39, seen);
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_first_again got=%0d want=0", seen); end
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL abort_ready_first got=%0b want=1", sample_ready); end
        pushSample(2'd0, 32'd1400);
        waitResult(lat);
        total++; if (lat !== LAT_DIV) begin bad++; $display("FAIL abort_latency got=%0d want=%0d", lat, LAT_DIV); end
        total++; if (vel_value !== 24'sd10000) begin bad++; $display("FAIL abort_value got=%0d want=10000", vel_value); end
        total++; if (vel_flags !== 2'b00) begin bad++; $display("FAIL abort_flags got=%b want=00", vel_flags); end
        releaseResult();
    endtask

    initial begin
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        sample_ch    = 2'd0;
        sample_disp  = 32'd0;
        vel_ready    = 1'b0;
        test_reset();
        test_first_and_latency();
        test_hold_stall();
        test_negative();
        test_zero_delta();
        test_stale();
        test_saturate();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/velocidad_canales.md
VELOCIDAD_CANALES -- requirements
Module: velocidad_canales

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent displacement channels, 1..16.
REQ-002 Parameter DISP_W, default 32: displacement sample width, unsigned.
REQ-003 Parameter TIME_W, default 24: per-channel elapsed-tick counter width.
REQ-004 Parameter VEL_W, default 24: signed velocity result width.
REQ-005 Parameter CLK_HZ, default 100000000: clock ticks per second, used as numerator scale.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-007 clock  in  1  sole clock; all state on its rising edge.
REQ-008 reset_n  in  1  asynchronous active-low reset.
REQ-009 sample_valid / sample_ready  in / out  1 each  input handshake; a transfer occurs when both are high.
REQ-010 sample_ch  in  clog2(CHANNELS)  channel index of the sample.
REQ-011 sample_disp  in  DISP_W  absolute displacement of that channel.
REQ-012 vel_valid / vel_ready  out / in  1 each  output handshake.
REQ-013 vel_ch  out  clog2(CHANNELS)  channel of the result.
REQ-014 vel_value  out  VEL_W signed  velocity in displacement units per second.
REQ-015 vel_flags  out  2  bit0 = stale (elapsed counter saturated), bit1 = result saturated.

Function
REQ-016 Each channel SHALL hold last_disp, a first_seen bit, and an elapsed counter that increments every cycle and saturates at 2^TIME_W-1.
REQ-017 On an accepted sample for a channel whose first_seen is 0: store disp, set first_seen, clear elapsed to 0, produce no output.
REQ-018 Otherwise: dd = sample_disp - last_disp (signed, DISP_W+1 bits), dt = elapsed+1; store disp, clear elapsed, start a division.
REQ-019 FSM states: IDLE -> LOAD -> DIVIDE -> SIGN -> HOLD -> IDLE; sample_ready is high only in IDLE.
REQ-020 LOAD forms numerator |dd|*CLK_HZ (NUM_W bits); DIVIDE runs a restoring divider one quotient bit per cycle for NUM_W cycles.
REQ-021 SIGN restores the sign of dd and saturates to [-2^(VEL_W-1), 2^(VEL_W-1)-1], setting flags bit1 on clamp.
REQ-022 vel_valid SHALL rise exactly NUM_W+3 cycles after the accepting edge; HOLD keeps all outputs stable until vel_ready.
REQ-023 If elapsed was saturated at acceptance: skip the division, vel_value = 0, flags bit0 = 1, vel_valid on the cycle after LOAD.
REQ-024 dd = 0 SHALL yield vel_value 0 through the normal division path, flags clear.
REQ-025 Elapsed counters of all channels SHALL keep counting during DIVIDE/HOLD; the counter of the accepted channel clears on the same edge.

Reset
REQ-026 reset_n low SHALL immediately clear FSM to IDLE, all first_seen, last_disp, elapsed to 0; vel_valid, vel_value, vel_ch, vel_flags to 0; sample_ready to 0 during reset, 1 on the first edge after release.
REQ-027 Reset asserted mid-division SHALL abort it with no output produced.

Configuration
REQ-028 With KMH_OUT_EN defined: extra output vel_kmh (VEL_W signed) = (vel_value*922)>>>8 (×3.6), saturated, valid with vel_valid.
REQ-029 Without KMH_OUT_EN: vel_kmh port and its multiplier do not exist.

Structure
REQ-030 Shared package velocidad_pkg SHALL hold the FSM state enum, flag bit indices, and the 922/8 km/h constants.
REQ-031 The divider SHALL be a sub-module div_restoring (parameter widths, start/done handshake).

Verification (bench: CHANNELS=4, CLK_HZ=1000, 10 ns clock)
REQ-032 ch0 disp 16430 then 16686 after 100 cycles -> first: no output; second: vel_value 2560, flags 00, latency NUM_W+3.
REQ-033 ch1 disp 17094 then 17018 after 50 cycles -> vel_value -1520.
REQ-034 ch2 samples 2^TIME_W+10 cycles apart -> vel_value 0, flags 01.
REQ-035 ch3 disp 0 then 2^DISP_W-1 after 1 cycle with VEL_W=24 -> vel_value 8388607, flags 10.
REQ-036 vel_ready held low 20 cycles -> outputs stable, sample_ready low; reset_n pulsed mid-DIVIDE -> no vel_valid, next ch0 sample treated as first.
